// File: rtl/gp_trigger_scheduler.sv
`timescale 1ns/1ps
// Trigger-path sequencer: loads four source configs, grants triggers round-robin and issues one
// handshaked operation per grant. Optional watchdog on WAIT_DONE: define GP_TRIG_WATCHDOG_EN.
module gp_trigger_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int WDT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [3:0]            i_trig,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] rd_trig_s1_config,
    input  logic [DATA_WIDTH-1:0] rd_trig_s2_config,
    input  logic [DATA_WIDTH-1:0] rd_trig_s3_config,
    input  logic [DATA_WIDTH-1:0] rd_trig_s4_config,
    input  logic                  reg_rd_valid,
    output logic                  o_req_valid,
    output logic [1:0]            o_req_src,
    output logic [15:0]           o_req_op,
    input  logic                  i_req_ready,
    input  logic                  i_op_done,
    output logic                  o_busy,
    output logic                  o_cfg_err,
    output logic                  o_timeout
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LOAD_WAIT, S_ARB, S_ISSUE, S_WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        trig_q;
    logic [3:0]        pending_q, pending_d;
    logic [3:0]        en_q, en_d;
    logic [3:0]        mode_q, mode_d;
    logic [3:0][15:0]  op_q, op_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [1:0]        req_src_q, req_src_d;
    logic [15:0]       req_op_q, req_op_d;
    logic              stop_seen_q, stop_seen_d;
    logic              req_valid_q, req_valid_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;

    logic [3:0]        edge_ev;
    logic [3:0]        req;
    logic              found;
    logic [1:0]        win;
    logic [1:0]        idx;
    logic              timeout;
    logic              op_end;
    logic              cfg_unused;

    // Only the enable, mode and op-code fields are kept; reserved bits are deliberately dropped.
    assign cfg_unused = ^{rd_trig_s1_config, rd_trig_s2_config, rd_trig_s3_config, rd_trig_s4_config};

    assign edge_ev = i_trig & ~trig_q;
    assign req     = en_q & ((mode_q & trig_q) | (~mode_q & pending_q));

`ifdef GP_TRIG_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_q, wdt_d;

    // Counter reads 0 on the first WAIT_DONE cycle, so expiry lands WDT_CYCLES cycles after entry.
    always_comb begin
        wdt_d = '0;
        if (state_q == S_WAIT_DONE && wdt_q != WDT_W'(WDT_CYCLES))
            wdt_d = wdt_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) wdt_q <= '0;
        else        wdt_q <= wdt_d;
    end

    assign timeout = (state_q == S_WAIT_DONE) && (wdt_q == WDT_W'(WDT_CYCLES)) && !i_op_done;
`else
    logic wdt_unused;
    assign wdt_unused = (WDT_CYCLES > 0);
    assign timeout    = 1'b0;
`endif

    assign op_end = i_op_done | timeout;

    // Circular search starting just after the last granted source.
    always_comb begin
        found = 1'b0;
        win   = last_grant_q;
        idx   = last_grant_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant_q + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        en_d         = en_q;
        mode_d       = mode_q;
        op_d         = op_q;
        last_grant_d = last_grant_q;
        req_src_d    = req_src_q;
        req_op_d     = req_op_q;
        stop_seen_d  = stop_seen_q;
        case (state_q)
            S_IDLE: begin
                pending_d   = '0;
                stop_seen_d = 1'b0;
                req_src_d   = '0;
                req_op_d    = '0;
                if (i_start) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                if (reg_rd_valid) begin
                    en_d    = {rd_trig_s4_config[0], rd_trig_s3_config[0],
                               rd_trig_s2_config[0], rd_trig_s1_config[0]};
                    mode_d  = {rd_trig_s4_config[1], rd_trig_s3_config[1],
                               rd_trig_s2_config[1], rd_trig_s1_config[1]};
                    op_d    = {rd_trig_s4_config[31:16], rd_trig_s3_config[31:16],
                               rd_trig_s2_config[31:16], rd_trig_s1_config[31:16]};
                    state_d = S_ARB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (found) begin
                    req_src_d    = win;
                    req_op_d     = op_q[win];
                    last_grant_d = win;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                stop_seen_d = stop_seen_q | i_stop;
                if (i_req_ready) begin
                    pending_d[req_src_q] = 1'b0;
                    state_d              = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                stop_seen_d = stop_seen_q | i_stop;
                if (op_end) begin
                    state_d     = (i_stop || stop_seen_q) ? S_IDLE : S_ARB;
                    stop_seen_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Applied after the handshake clear so a coincident new edge is not lost.
        if (state_q inside {S_ARB, S_ISSUE, S_WAIT_DONE})
            pending_d = pending_d | (edge_ev & en_q & ~mode_q);
        rd_en_d     = (state_d == S_LOAD);
        req_valid_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            state_q      <= S_IDLE;
            trig_q       <= '0;
            pending_q    <= '0;
            en_q         <= '0;
            mode_q       <= '0;
            op_q         <= '0;
            last_grant_q <= 2'd3;
            req_src_q    <= '0;
            req_op_q     <= '0;
            stop_seen_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_q       <= i_trig;
            pending_q    <= pending_d;
            en_q         <= en_d;
            mode_q       <= mode_d;
            op_q         <= op_d;
            last_grant_q <= last_grant_d;
            req_src_q    <= req_src_d;
            req_op_q     <= req_op_d;
            stop_seen_q  <= stop_seen_d;
            req_valid_q  <= req_valid_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
        end
    end

    assign reg_rd_en   = rd_en_q;
    assign o_req_valid = req_valid_q;
    assign o_req_src   = req_src_q;
    assign o_req_op    = req_op_q;
    assign o_busy      = busy_q;
    assign o_cfg_err   = (state_q == S_LOAD_WAIT) && !reg_rd_valid;
    assign o_timeout   = timeout;

endmodule

// File: tb/tb_gp_trigger_scheduler.sv
`timescale 1ns/1ps
// Directed and randomized bench for gp_trigger_scheduler; expected grants come from a
// transaction-level round-robin model kept in this file.
module tb_gp_trigger_scheduler;
    localparam int DW = 32;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b1;
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic [3:0]    i_trig = '0;
    logic          reg_rd_en;
    logic [DW-1:0] cfg1 = '0, cfg2 = '0, cfg3 = '0, cfg4 = '0;
    logic          reg_rd_valid = 1'b0;
    logic          o_req_valid;
    logic [1:0]    o_req_src;
    logic [15:0]   o_req_op;
    logic          i_req_ready = 1'b0;
    logic          i_op_done = 1'b0;
    logic          o_busy;
    logic          o_cfg_err;
    logic          o_timeout;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit         m_en [4];
    bit         m_lvl [4];
    bit         m_pend [4];
    logic [15:0] m_op [4];
    int         m_last = 3;
    logic [3:0] lvl_bits = '0;

    always #5 i_clk = ~i_clk;

    gp_trigger_scheduler #(.DATA_WIDTH(DW), .WDT_CYCLES(16)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_stop(i_stop), .i_trig(i_trig),
        .reg_rd_en(reg_rd_en),
        .rd_trig_s1_config(cfg1), .rd_trig_s2_config(cfg2),
        .rd_trig_s3_config(cfg3), .rd_trig_s4_config(cfg4),
        .reg_rd_valid(reg_rd_valid), .o_req_valid(o_req_valid), .o_req_src(o_req_src),
        .o_req_op(o_req_op), .i_req_ready(i_req_ready), .i_op_done(i_op_done),
        .o_busy(o_busy), .o_cfg_err(o_cfg_err), .o_timeout(o_timeout)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rstn = 1'b1;
        repeat (2) tick();
        i_rstn = 1'b0;
        tick();
        m_last = 3;
    endtask

    task automatic load();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check_val("load_rd_en", 32'(reg_rd_en), 32'd1);
        tick();
        check_val("load_no_err", 32'(o_cfg_err), 32'd0);
        tick();
        check_val("load_busy", 32'(o_busy), 32'd1);
        check_val("load_rd_en_off", 32'(reg_rd_en), 32'd0);
    endtask

    task automatic pulse_trig(input logic [3:0] b);
        logic [3:0] save;
        save   = i_trig;
        i_trig = save | b;
        tick();
        i_trig = save;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!o_req_valid && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    // Wait for a request, check it, hold ready low for 'stall' cycles, then handshake.
    task automatic serve(input logic [1:0] src, input logic [15:0] op, input int stall,
                         input logic [3:0] retrig, output int lat);
        logic [3:0] save;
        wait_valid(30, lat);
        check_val("req_valid", 32'(o_req_valid), 32'd1);
        check_val("req_src", 32'(o_req_src), 32'(src));
        check_val("req_op", 32'(o_req_op), 32'(op));
        for (int k = 0; k < stall; k++) begin
            tick();
            check_val("stall_valid", 32'(o_req_valid), 32'd1);
            check_val("stall_src", 32'(o_req_src), 32'(src));
            check_val("stall_op", 32'(o_req_op), 32'(op));
        end
        save        = i_trig;
        i_trig      = save | retrig;
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        i_trig      = save;
        check_val("post_hs_valid", 32'(o_req_valid), 32'd0);
    endtask

    task automatic done();
        i_op_done = 1'b1;
        tick();
        i_op_done = 1'b0;
    endtask

    function automatic int model_pick();
        for (int k = 1; k <= 4; k++) begin
            int n;
            n = (m_last + k) % 4;
            if (m_en[n] && (m_lvl[n] ? lvl_bits[n] : m_pend[n])) return n;
        end
        return -1;
    endfunction

    initial begin
        #400000;
        $display("FAIL global_timeout: time %0t exceeded bound", $time);
        $fatal(1, "bench time bound expired");
    end

    initial begin
        int lat;
        logic [31:0] cfg [4];

        // Reset state
        do_reset();
        check_val("rst_valid", 32'(o_req_valid), 32'd0);
        check_val("rst_src", 32'(o_req_src), 32'd0);
        check_val("rst_op", 32'(o_req_op), 32'd0);
        check_val("rst_rd_en", 32'(reg_rd_en), 32'd0);
        check_val("rst_busy", 32'(o_busy), 32'd0);
        check_val("rst_cfg_err", 32'(o_cfg_err), 32'd0);
        check_val("rst_timeout", 32'(o_timeout), 32'd0);

        // Failed load
        reg_rd_valid = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check_val("err_rd_en", 32'(reg_rd_en), 32'd1);
        check_val("err_busy_t1", 32'(o_busy), 32'd1);
        tick();
        check_val("err_pulse", 32'(o_cfg_err), 32'd1);
        tick();
        check_val("err_pulse_end", 32'(o_cfg_err), 32'd0);
        check_val("err_idle_busy", 32'(o_busy), 32'd0);
        reg_rd_valid = 1'b1;

        // Two simultaneous edges, stalled handshake, start ignored outside IDLE
        do_reset();
        cfg1 = 32'hA5A5_0001; cfg2 = '0; cfg3 = 32'h3C3C_0001; cfg4 = '0;
        load();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check_val("start_ignored", 32'(reg_rd_en), 32'd0);
        pulse_trig(4'b0101);
        serve(2'd0, 16'hA5A5, 3, 4'b0000, lat);
        check_val("edge_lat", 32'(lat), 32'd1);
        done();
        serve(2'd2, 16'h3C3C, 0, 4'b0000, lat);
        check_val("b2b_lat", 32'(lat), 32'd1);
        done();
        tick();
        check_val("edge_drained", 32'(o_req_valid), 32'd0);

        // Level mode, all sources requesting
        do_reset();
        cfg1 = 32'h0001_0003; cfg2 = 32'h0001_0003; cfg3 = 32'h0001_0003; cfg4 = 32'h0001_0003;
        i_trig = 4'hF;
        tick();
        load();
        for (int g = 0; g < 5; g++) begin
            serve(2'(g % 4), 16'h0001, 0, 4'b0000, lat);
            check_val("lvl_lat", 32'(lat), 32'd1);
            done();
        end
        wait_valid(10, lat);
        check_val("lvl_sixth", 32'(o_req_src), 32'd1);
        i_rstn = 1'b1;
        #1;
        check_val("async_rst_valid", 32'(o_req_valid), 32'd0);
        check_val("async_rst_busy", 32'(o_busy), 32'd0);
        i_trig = '0;
        tick();
        i_rstn = 1'b0;
        tick();
        m_last = 3;

        // Re-trigger on the handshake cycle
        cfg1 = 32'h1111_0001; cfg2 = '0; cfg3 = '0; cfg4 = '0;
        load();
        pulse_trig(4'b0001);
        serve(2'd0, 16'h1111, 1, 4'b0001, lat);
        done();
        serve(2'd0, 16'h1111, 0, 4'b0000, lat);
        done();
        repeat (3) begin
            tick();
            check_val("retrig_once", 32'(o_req_valid), 32'd0);
        end

        // Stop during ISSUE
        do_reset();
        cfg1 = 32'h2222_0001;
        load();
        pulse_trig(4'b0001);
        wait_valid(10, lat);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check_val("stop_hold_valid", 32'(o_req_valid), 32'd1);
        serve(2'd0, 16'h2222, 0, 4'b0000, lat);
        done();
        check_val("stop_idle_busy", 32'(o_busy), 32'd0);
        for (int k = 0; k < 8; k++) begin
            i_trig = {3'b000, k[0]};
            tick();
            check_val("stop_no_req", 32'(o_req_valid), 32'd0);
        end
        i_trig = '0;

        // Watchdog
        do_reset();
        cfg1 = 32'h7777_0001;
        load();
        pulse_trig(4'b0001);
        serve(2'd0, 16'h7777, 0, 4'b0000, lat);
`ifdef GP_TRIG_WATCHDOG_EN
        for (int k = 0; k < 16; k++) begin
            check_val("wdt_early", 32'(o_timeout), 32'd0);
            tick();
        end
        check_val("wdt_pulse", 32'(o_timeout), 32'd1);
        tick();
        check_val("wdt_pulse_end", 32'(o_timeout), 32'd0);
        check_val("wdt_busy", 32'(o_busy), 32'd1);
        pulse_trig(4'b0001);
        serve(2'd0, 16'h7777, 0, 4'b0000, lat);
        done();
`else
        for (int k = 0; k < 40; k++) begin
            tick();
            check_val("no_wdt_timeout", 32'(o_timeout), 32'd0);
        end
        check_val("no_wdt_busy", 32'(o_busy), 32'd1);
        done();
        tick();
        check_val("no_wdt_arb", 32'(o_req_valid), 32'd0);
`endif

        // Randomized configurations and trigger patterns against the model
        do_reset();
        for (int s = 0; s < 6; s++) begin
            logic [3:0] lvl_mask;
            bit outstanding;
            for (int n = 0; n < 4; n++) begin
                cfg[n]    = $urandom();
                m_en[n]   = cfg[n][0];
                m_lvl[n]  = cfg[n][1];
                m_op[n]   = cfg[n][31:16];
                m_pend[n] = 1'b0;
                lvl_mask[n] = cfg[n][1];
            end
            cfg1 = cfg[0]; cfg2 = cfg[1]; cfg3 = cfg[2]; cfg4 = cfg[3];
            i_trig = '0;
            lvl_bits = '0;
            tick();
            load();
            cfg1 = $urandom(); cfg2 = $urandom(); cfg3 = $urandom(); cfg4 = $urandom();
            outstanding = 1'b0;
            for (int r = 0; r < 12; r++) begin
                logic [3:0] lvl_new, edg;
                int p;
                lvl_new = 4'($urandom_range(0, 15)) & lvl_mask;
                edg     = 4'($urandom_range(0, 15)) & ~lvl_mask;
                i_trig = lvl_new | edg;
                tick();
                i_trig = lvl_new;
                tick();
                for (int n = 0; n < 4; n++)
                    if (edg[n] && m_en[n]) m_pend[n] = 1'b1;
                lvl_bits = lvl_new;
                if (outstanding) done();
                p = model_pick();
                if (p >= 0) begin
                    serve(2'(p), m_op[p], $urandom_range(0, 2), 4'b0000, lat);
                    m_last = p;
                    if (!m_lvl[p]) m_pend[p] = 1'b0;
                    outstanding = 1'b1;
                end else begin
                    repeat (4) begin
                        tick();
                        check_val("rand_no_req", 32'(o_req_valid), 32'd0);
                    end
                    outstanding = 1'b0;
                end
            end
            i_trig    = '0;
            i_stop    = 1'b1;
            i_op_done = outstanding;
            tick();
            i_stop    = 1'b0;
            i_op_done = 1'b0;
            check_val("rand_idle_busy", 32'(o_busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gp_trigger_scheduler.md
# gp_trigger_scheduler

Control sequencer for the GP engine trigger path. It loads the four trigger-source configuration words from the GP engine register file through the FSM read port (`reg_rd_en` / `reg_rd_valid`), then watches the four trigger inputs. Pending triggers are granted round-robin. For each grant it issues one operation request to the downstream engine datapath over a valid/ready handshake and waits for completion before it arbitrates again.

## Interface
Parameters:
- `DATA_WIDTH`, 32: configuration word width; must be ≥ 32.
- `WDT_CYCLES`, 1024: watchdog limit in `WAIT_DONE`; used only with `GP_TRIG_WATCHDOG_EN`.

Ports:
- `i_clk`  in  1  clock.
- `i_rstn`  in  1  reset; asynchronous, active-high.
- `i_start`  in  1  one-cycle pulse that starts a configuration load and then run; honoured only in `IDLE`.
- `i_stop`  in  1  level; requests return to `IDLE`.
- `i_trig`  in  4  trigger inputs, synchronous to `i_clk`; bit n is source n+1.
- `reg_rd_en`  out  1  register-file read enable.
- `rd_trig_s1_config`..`rd_trig_s4_config`  in  DATA_WIDTH each  configuration words.
- `reg_rd_valid`  in  1  configuration words valid.
- `o_req_valid`  out  1  operation request valid.
- `o_req_src`  out  2  granted source index, 0..3.
- `o_req_op`  out  16  operation code, taken from config[31:16].
- `i_req_ready`  in  1  downstream accepts the request.
- `i_op_done`  in  1  one-cycle pulse: the operation has completed.
- `o_busy`  out  1  high in every state except `IDLE`.
- `o_cfg_err`  out  1  one-cycle pulse: the load returned no valid configuration.
- `o_timeout`  out  1  one-cycle pulse: watchdog expired (always 0 without the macro).

## Operation
- Configuration word fields:
  - bit0 = enable.
  - bit1 = mode: 0 = rising edge, 1 = level-high.
  - [31:16] = op code.
  - All other bits are reserved and ignored.
- State `IDLE`:
  - Outputs are idle and all pending bits are cleared.
  - `i_start` moves to `LOAD`.
- State `LOAD`:
  - `reg_rd_en` is high for exactly one cycle.
  - Next state is `LOAD_WAIT`.
- State `LOAD_WAIT` (one cycle):
  - If `reg_rd_valid`=1: capture all four words into internal shadow registers, go to `ARB`.
  - Otherwise: pulse `o_cfg_err` and go to `IDLE`.
- Edge-mode sources:
  - `i_trig` is registered once to form `trig_q`.
  - An event is `i_trig & ~trig_q`. It sets `pending[n]` if the source is enabled and the state is `ARB`, `ISSUE` or `WAIT_DONE`.
- Level-mode sources: request whenever enabled and `trig_q`[n]=1. These sources are never latched.
- Disabled sources never request.
- State `ARB`:
  - If `i_stop`=1, go to `IDLE`.
  - Otherwise pick the first requesting source, searching circularly from `last_grant`+1; the reset value of `last_grant` is 3, so source 0 is checked first.
  - On a winner, register `o_req_src`/`o_req_op`, update `last_grant` and go to `ISSUE`.
  - With no request, stay in `ARB`.
- State `ISSUE`:
  - `o_req_valid`=1; `o_req_src` and `o_req_op` are held stable until `i_req_ready`.
  - On the handshake cycle (`o_req_valid` & `i_req_ready`): clear `pending[src]` and go to `WAIT_DONE`.
- State `WAIT_DONE`:
  - On `i_op_done`: go to `IDLE` if `i_stop` is high or was seen during the operation (`stop_seen` flag), otherwise go to `ARB`.
  - `i_op_done` received in any other state is ignored.
- Configuration changes in the register file take effect only on the next `i_start`.

## Timing
- Reset values:
  - All outputs 0.
  - State `IDLE`; pending 0; shadow configs 0; `trig_q` 0; `last_grant` 3; `stop_seen` 0.
- Load latency: `i_start` at cycle T → `reg_rd_en` at T+1 → `reg_rd_valid` sampled at T+2 → `ARB` at T+3.
- Grant latency: a request present in `ARB` at cycle C → `o_req_valid` at C+1. An edge event adds one cycle of registration.
- Simultaneous set and clear of `pending[n]` on the handshake cycle: set wins, so a new edge is not lost.
- `i_stop` in `ISSUE` does not drop `o_req_valid`; the handshake and the operation complete first, then the block goes to `IDLE`.
- `i_start` outside `IDLE` is ignored.
- Reset mid-operation: all state clears immediately and `o_req_valid` drops asynchronously.
- Back-to-back operations: `i_op_done` at D → `ARB` at D+1 → `o_req_valid` at D+2.

## Configuration
- `GP_TRIG_WATCHDOG_EN` defined:
  - A counter runs in `WAIT_DONE` and is cleared on entry.
  - When it reaches `WDT_CYCLES` with no `i_op_done`, the block pulses `o_timeout` and continues exactly as if `i_op_done` had arrived.
- `GP_TRIG_WATCHDOG_EN` undefined:
  - No counter is built and `o_timeout` is tied to 0.
  - `WAIT_DONE` waits indefinitely for `i_op_done`.

## Test plan
- Load with all configs 0 (`reg_rd_valid`=0): `i_start` → `o_cfg_err` pulse at T+2; block back in `IDLE` with `o_busy`=0 at T+3.
- Configs s1=0xA5A5_0001 and s3=0x3C3C_0001; rising edges on `i_trig`[0] and `i_trig`[2] in the same cycle:
  - Expected grants in order: src 0 with op 0xA5A5, then src 2 with op 0x3C3C.
  - `o_req_valid` is held through a 3-cycle `i_req_ready` stall.
- All four sources in level mode (config 0x0001_0003) with `i_trig`=4'hF held high: grants cycle 0,1,2,3,0 across five operations.
- Edge source 0 re-triggers on the handshake cycle → `pending[0]` stays set and a second request for src 0 follows.
- `i_stop` asserted during `ISSUE` → request completes, then `IDLE` after `i_op_done`; with `i_trig` toggling afterwards, `o_req_valid` stays 0.
- With `GP_TRIG_WATCHDOG_EN` and `WDT_CYCLES`=16, `i_op_done` withheld → `o_timeout` pulse 16 cycles after entering `WAIT_DONE`, then the block returns to `ARB`.
